clk_div_multi: RTL and testbench

Multi-channel programmable clock divider. It generates CHANNELS independent divided clock-enable waveforms from one reference clock. Each channel has a run-time programmable period and high time, a per-channel enable, and a period-start tick. New settings are applied glitch-free only at a period boundary. Used wherever several slow clocks or strobes are needed from the system clock without a rebuild per frequency.

---
 rtl/clk_div_multi.sv | 109 ++++++++++
 tb/tb_clk_div_multi.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel period/high-time counters with
// shadowed configuration that takes effect only at a period boundary or while disabled.
module clk_div_multi #(
  parameter int CHANNELS       = 4,
  parameter int NBITS          = 16,
  parameter int SELW           = 2,
  parameter int DEFAULT_PERIOD = 2,
  parameter int DEFAULT_HIGH   = 1
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_wr,
  input  logic [SELW-1:0]     cfg_sel,
  input  logic [NBITS-1:0]    cfg_period,
  input  logic [NBITS-1:0]    cfg_high,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  function automatic logic [NBITS-1:0] clamp_period(input logic [NBITS-1:0] p);
    return (p < NBITS'(2)) ? NBITS'(2) : p;
  endfunction

  function automatic logic [NBITS-1:0] clamp_high(input logic [NBITS-1:0] h,
                                                  input logic [NBITS-1:0] p);
    logic [NBITS-1:0] pe;
    pe = clamp_period(p);
    return (h > pe) ? pe : h;
  endfunction

  localparam logic [NBITS-1:0] DEF_P = clamp_period(NBITS'(DEFAULT_PERIOD));
  localparam logic [NBITS-1:0] DEF_H = clamp_high(NBITS'(DEFAULT_HIGH), NBITS'(DEFAULT_PERIOD));

  logic [NBITS-1:0] p_act [CHANNELS];
  logic [NBITS-1:0] h_act [CHANNELS];
  logic [NBITS-1:0] p_sh  [CHANNELS];
  logic [NBITS-1:0] h_sh  [CHANNELS];
  logic [NBITS-1:0] cnt   [CHANNELS];

  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] boundary;
  logic [CHANNELS-1:0] apply;
  logic [NBITS-1:0]    p_new [CHANNELS];
  logic [NBITS-1:0]    h_new [CHANNELS];

  // Stage p0: decode write target, detect boundaries, select settings for the next period
  always_comb begin
    wr_hit   = '0;
    boundary = '0;
    apply    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      p_new[i]    = p_act[i];
      h_new[i]    = h_act[i];
      wr_hit[i]   = cfg_wr && (cfg_sel == SELW'(i));
      boundary[i] = en[i] && (cnt[i] == p_act[i] - NBITS'(1));
      // A write landing on this edge wins over applying the older shadow contents
      apply[i]    = pending[i] && !wr_hit[i] && (boundary[i] || !en[i]);
      if (apply[i]) begin
        p_new[i] = clamp_period(p_sh[i]);
        h_new[i] = clamp_high(h_sh[i], p_sh[i]);
      end
    end
  end

  // Stage p1: registered counters, active/shadow settings and outputs
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        p_act[i]   <= DEF_P;
        h_act[i]   <= DEF_H;
        p_sh[i]    <= DEF_P;
        h_sh[i]    <= DEF_H;
        cnt[i]     <= DEF_P - NBITS'(1);
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
        pending[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        p_act[i] <= p_new[i];
        h_act[i] <= h_new[i];
        if (wr_hit[i]) begin
          p_sh[i]    <= cfg_period;
          h_sh[i]    <= cfg_high;
          pending[i] <= 1'b1;
        end else if (apply[i]) begin
          pending[i] <= 1'b0;
        end
        if (!en[i]) begin
          // Parking at P-1 makes the first enabled edge a boundary
          cnt[i]     <= p_new[i] - NBITS'(1);
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (boundary[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= (h_new[i] != '0);
          tick[i]    <= 1'b1;
        end else begin
          cnt[i]     <= cnt[i] + NBITS'(1);
          clk_out[i] <= ((cnt[i] + NBITS'(1)) < h_act[i]);
          tick[i]    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi (3 channels so that cfg_sel=3 is out of range):
// directed per-cycle vectors push expected outputs, a monitor pops after each clock edge.
module tb_clk_div_multi;
  logic        clk_in;
  logic        reset;
  logic [2:0]  en;
  logic        cfg_wr;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_period;
  logic [15:0] cfg_high;
  logic [2:0]  clk_out;
  logic [2:0]  tick;
  logic [2:0]  pending;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] m;
    logic [2:0] c;
    logic [2:0] t;
    logic [2:0] p;
    string      nm;
  } exp_t;
  exp_t q[$];

  clk_div_multi #(
    .CHANNELS(3), .NBITS(16), .SELW(2), .DEFAULT_PERIOD(2), .DEFAULT_HIGH(1)
  ) dut (
    .clk_in(clk_in), .reset(reset), .en(en), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel),
    .cfg_period(cfg_period), .cfg_high(cfg_high),
    .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Monitor: one expected entry per rising edge, compared 2 time units after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ((((clk_out ^ e.c) | (tick ^ e.t) | (pending ^ e.p)) & e.m) != 3'b000) begin
          errors++;
          $display("FAIL %s: clk_out=%b tick=%b pending=%b, want clk_out=%b tick=%b pending=%b (mask %b)",
                   e.nm, clk_out, tick, pending, e.c, e.t, e.p, e.m);
        end
      end
    end
  end

  // Drive one cycle of stimulus at a falling edge and queue the response after the next rising edge
  task automatic step(input logic [2:0] e, input logic w, input logic [1:0] s,
                      input logic [15:0] p, input logic [15:0] h,
                      input logic [2:0] m, input logic [2:0] ec, input logic [2:0] et,
                      input logic [2:0] ep, input string nm);
    exp_t x;
    en = e; cfg_wr = w; cfg_sel = s; cfg_period = p; cfg_high = h;
    x.m = m; x.c = ec; x.t = et; x.p = ep; x.nm = nm;
    q.push_back(x);
    @(negedge clk_in);
  endtask

  // Assert reset between edges, check outputs clear at once, release on a falling edge
  task automatic do_reset(input string nm);
    #2;
    reset = 1'b0;
    cfg_wr = 1'b0;
    #1;
    checks++;
    if (clk_out != 3'b000 || tick != 3'b000 || pending != 3'b000) begin
      errors++;
      $display("FAIL %s: clk_out=%b tick=%b pending=%b, want all 000", nm, clk_out, tick, pending);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; en = 3'b111; cfg_wr = 1'b0; cfg_sel = 2'd0;
    cfg_period = 16'd0; cfg_high = 16'd0;

    // Reset defaults P=2 H=1 on all channels
    do_reset("reset_init");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b111, 3'b000, "def_e1");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "def_e2");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b111, 3'b000, "def_e3");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "def_e4");

    // ch0 P=5 H=2 written while disabled; others keep running at P=2
    step(3'b110, 1, 0, 5, 2, 3'b111, 3'b110, 3'b110, 3'b001, "p5_wr");
    step(3'b110, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "p5_apply");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b111, 3'b000, "p5_c0");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b001, 3'b000, 3'b000, "p5_c1");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b110, 3'b110, 3'b000, "p5_c2");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "p5_c3");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b110, 3'b110, 3'b000, "p5_c4");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b001, 3'b001, 3'b000, "p5_c0b");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b110, 3'b000, "p5_c1b");

    // ch1 runs P=6 H=3, reprogrammed to P=4 H=1 mid-period
    do_reset("reset_b");
    step(3'b000, 1, 1, 6, 3, 3'b111, 3'b000, 3'b000, 3'b010, "mid_wr6");
    step(3'b000, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "mid_ap6");
    step(3'b010, 0, 0, 0, 0, 3'b111, 3'b010, 3'b010, 3'b000, "mid_h0");
    step(3'b010, 0, 0, 0, 0, 3'b111, 3'b010, 3'b000, 3'b000, "mid_h1");
    step(3'b010, 0, 0, 0, 0, 3'b111, 3'b010, 3'b000, 3'b000, "mid_h2");
    step(3'b010, 1, 1, 4, 1, 3'b111, 3'b000, 3'b000, 3'b010, "mid_l3_wr");
    step(3'b010, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b010, "mid_l4");
    step(3'b010, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b010, "mid_l5");
    step(3'b010, 0, 0, 0, 0, 3'b111, 3'b010, 3'b010, 3'b000, "mid_new0");
    step(3'b010, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "mid_new1");
    step(3'b010, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "mid_new2");
    step(3'b010, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "mid_new3");
    step(3'b010, 0, 0, 0, 0, 3'b111, 3'b010, 3'b010, 3'b000, "mid_new4");

    // Clamps: ch0 P=0 H=0, ch1 P=3 H=9, ch2 P=1 H=1
    do_reset("reset_c");
    step(3'b000, 1, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b001, "clp_wr0");
    step(3'b000, 1, 1, 3, 9, 3'b111, 3'b000, 3'b000, 3'b010, "clp_wr1");
    step(3'b000, 1, 2, 1, 1, 3'b111, 3'b000, 3'b000, 3'b100, "clp_wr2");
    step(3'b000, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "clp_ap");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b110, 3'b111, 3'b000, "clp_e1");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b010, 3'b000, 3'b000, "clp_e2");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b110, 3'b101, 3'b000, "clp_e3");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b010, 3'b010, 3'b000, "clp_e4");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b110, 3'b101, 3'b000, "clp_e5");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b010, 3'b000, 3'b000, "clp_e6");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b110, 3'b111, 3'b000, "clp_e7");

    // Same-edge write at a boundary and an out-of-range cfg_sel
    do_reset("reset_d");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b111, 3'b000, "se_e1");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "se_e2");
    step(3'b111, 1, 0, 3, 2, 3'b111, 3'b111, 3'b111, 3'b001, "se_wr_bnd");
    step(3'b111, 1, 3, 7, 7, 3'b111, 3'b000, 3'b000, 3'b001, "se_bad_sel");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b111, 3'b000, "se_apply");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b001, 3'b000, 3'b000, "se_n1");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b110, 3'b110, 3'b000, "se_n2");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b001, 3'b001, 3'b000, "se_n3");
    step(3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b110, 3'b000, "se_n4");

    // ch2 P=4 H=2: en toggled mid-period, then reset while clk_out[2] is high
    do_reset("reset_e");
    step(3'b000, 1, 2, 4, 2, 3'b111, 3'b000, 3'b000, 3'b100, "en_wr");
    step(3'b000, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "en_ap");
    step(3'b100, 0, 0, 0, 0, 3'b111, 3'b100, 3'b100, 3'b000, "en_c0");
    step(3'b100, 0, 0, 0, 0, 3'b111, 3'b100, 3'b000, 3'b000, "en_c1");
    step(3'b100, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "en_c2");
    step(3'b000, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "en_off");
    step(3'b100, 0, 0, 0, 0, 3'b111, 3'b100, 3'b100, 3'b000, "en_re0");
    step(3'b100, 0, 0, 0, 0, 3'b111, 3'b100, 3'b000, 3'b000, "en_re1");
    do_reset("reset_mid");
    step(3'b100, 0, 0, 0, 0, 3'b111, 3'b100, 3'b100, 3'b000, "rst_c0");
    step(3'b100, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, "rst_c1");
    step(3'b100, 0, 0, 0, 0, 3'b111, 3'b100, 3'b100, 3'b000, "rst_c2");

    @(negedge clk_in);
    @(negedge clk_in);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
